// File: rtl/memory_bist_controller_pkg.sv
// rtl/memory_bist_controller_pkg.sv - shared FSM state type and size defaults for the memory BIST controller
package memory_bist_controller_pkg;

  localparam int DEPTH_DEFAULT  = 32;
  localparam int ADDR_W_DEFAULT = 5;
  localparam int DATA_W_DEFAULT = 32;

  // Mismatch counter width; the counter saturates at its all-ones value.
  localparam int FAIL_COUNT_W = 7;
  localparam logic [FAIL_COUNT_W-1:0] FAIL_COUNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    FINISH
  } state_t;

endpackage

// File: rtl/bist_addr_counter.sv
// rtl/bist_addr_counter.sv - word address counter with clear, enable and terminal-count flag
module bist_addr_counter
  import memory_bist_controller_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [ADDR_W-1:0] count,
  output logic              terminal
);

  assign terminal = (count == ADDR_W'(DEPTH - 1));

  // Step one word per enabled cycle, wrapping to 0 after the last word.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/memory_bist_controller.sv
// rtl/memory_bist_controller.sv - memory BIST top (write/read-compare); BIST_INVERT_PASS_EN adds an inverted second pass
module memory_bist_controller
  import memory_bist_controller_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       pattern,
  output logic [DATA_W-1:0]       mem_data,
  output logic [ADDR_W-1:0]       mem_address,
  output logic                    mem_rE,
  output logic                    mem_wE,
  input  logic [DATA_W-1:0]       mem_dataOut,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ADDR_W-1:0]       fail_address,
  output logic [FAIL_COUNT_W-1:0] fail_count
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic              addr_last;
  logic              addr_clear;
  logic              addr_enable;
  logic [DATA_W-1:0] seed;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              invert;
  logic              mismatch;
  logic              start_accept;

  // Word written at address a, and expected back from it; the second pass uses the complement.
  function automatic logic [DATA_W-1:0] expected_word(input logic [DATA_W-1:0] s,
                                                      input logic [ADDR_W-1:0] a,
                                                      input logic              inv);
    logic [DATA_W-1:0] w;
    w = s ^ DATA_W'(a);
    return inv ? ~w : w;
  endfunction

  bist_addr_counter #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_addr_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (addr_clear),
    .enable  (addr_enable),
    .count   (addr),
    .terminal(addr_last)
  );

  assign start_accept = (state == IDLE) && start;
  assign busy         = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign mismatch     = rd_valid && (mem_dataOut != expected_word(seed, rd_addr, invert));

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and memory strobes; address and data are held at 0 outside WRITE/READ.
  always_comb begin
    state_next  = state;
    addr_clear  = 1'b0;
    addr_enable = 1'b0;
    mem_wE      = 1'b0;
    mem_rE      = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = WRITE;
          addr_clear = 1'b1;
        end
      end
      WRITE: begin
        addr_enable = 1'b1;
        mem_wE      = 1'b1;
        mem_address = addr;
        mem_data    = expected_word(seed, addr, invert);
        if (addr_last) state_next = READ;
      end
      READ: begin
        addr_enable = 1'b1;
        mem_rE      = 1'b1;
        mem_address = addr;
        if (addr_last) state_next = DRAIN;
      end
      DRAIN: begin
`ifdef BIST_INVERT_PASS_EN
        if (!invert) begin
          state_next = WRITE;
          addr_clear = 1'b1;
        end else begin
          state_next = FINISH;
        end
`else
        state_next = FINISH;
`endif
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef BIST_INVERT_PASS_EN
  // Second-pass flag: raised when the first DRAIN completes, dropped when a new run starts.
  always_ff @(posedge clock) begin
    if (reset || start_accept) begin
      invert <= 1'b0;
    end else if (state == DRAIN) begin
      invert <= 1'b1;
    end
  end
`else
  assign invert = 1'b0;
`endif

  // One-cycle read pipeline, seed capture, mismatch accounting and result flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      seed         <= '0;
      rd_valid     <= 1'b0;
      rd_addr      <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_address <= '0;
      fail_count   <= '0;
    end else begin
      rd_valid <= (state == READ);
      rd_addr  <= addr;
      if (start_accept) begin
        seed         <= pattern;
        done         <= 1'b0;
        pass         <= 1'b0;
        fail_address <= '0;
        fail_count   <= '0;
      end else begin
        if (mismatch) begin
          if (fail_count == '0) fail_address <= rd_addr;
          if (fail_count != FAIL_COUNT_MAX) fail_count <= fail_count + FAIL_COUNT_W'(1);
        end
        if (state == FINISH) begin
          done <= 1'b1;
          pass <= (fail_count == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_bist_controller.sv
// tb/tb_memory_bist_controller.sv - randomized self-checking bench for memory_bist_controller
module tb_memory_bist_controller;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
`ifdef BIST_INVERT_PASS_EN
  localparam int PASSES  = 2;
  localparam int RUN_LEN = 4 * DEPTH + 3;
`else
  localparam int PASSES  = 1;
  localparam int RUN_LEN = 2 * DEPTH + 2;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] pattern;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_rE;
  logic              mem_wE;
  logic [DATA_W-1:0] mem_dataOut = '0;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W-1:0] fail_address;
  logic [6:0]        fail_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] mem    [DEPTH];
  logic [DATA_W-1:0] force1 [DEPTH];
  logic [DATA_W-1:0] force0 [DEPTH];

  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [DATA_W-1:0] wr_data_q [$];
  logic [ADDR_W-1:0] rd_addr_q [$];
  bit overlap_seen;
  bit idle_dirty;

  memory_bist_controller dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pattern     (pattern),
    .mem_data    (mem_data),
    .mem_address (mem_address),
    .mem_rE      (mem_rE),
    .mem_wE      (mem_wE),
    .mem_dataOut (mem_dataOut),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_address(fail_address),
    .fail_count  (fail_count)
  );

  always #5 clock = ~clock;

  // Synchronous memory with one-cycle read latency and per-bit stuck-at faults on read.
  always @(posedge clock) begin
    if (mem_wE) mem[mem_address] <= mem_data;
    if (mem_rE) mem_dataOut <= (mem[mem_address] | force1[mem_address]) & ~force0[mem_address];
  end

  // Bus monitor sampled mid-cycle.
  always @(negedge clock) begin
    if (mem_wE && mem_rE) overlap_seen = 1'b1;
    if (!mem_wE && !mem_rE && (mem_address != '0 || mem_data != '0)) idle_dirty = 1'b1;
    if (mem_wE) begin
      wr_addr_q.push_back(mem_address);
      wr_data_q.push_back(mem_data);
    end
    if (mem_rE) rd_addr_q.push_back(mem_address);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      force1[a] = '0;
      force0[a] = '0;
    end
  endtask

  task automatic clear_monitor();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    overlap_seen = 1'b0;
    idle_dirty   = 1'b0;
  endtask

  // Word the test should write to address a on pass p.
  function automatic logic [DATA_W-1:0] ref_word(input logic [DATA_W-1:0] s, input int a, input int p);
    logic [DATA_W-1:0] w;
    w = s ^ DATA_W'(a);
    return (p == 1) ? ~w : w;
  endfunction

  // Reference result: every read whose faulted value differs from what was written is a mismatch.
  task automatic model_run(input logic [DATA_W-1:0] s, output int exp_count, output int exp_addr);
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] r;
    exp_count = 0;
    exp_addr  = 0;
    for (int p = 0; p < PASSES; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        e = ref_word(s, a, p);
        r = (e | force1[a]) & ~force0[a];
        if (r != e) begin
          if (exp_count == 0) exp_addr = a;
          if (exp_count < 127) exp_count++;
        end
      end
    end
  endtask

  task automatic run_test(input string tag, input logic [DATA_W-1:0] s, input bit hold);
    int cyc;
    int exp_count;
    int exp_addr;
    int werr;
    int rerr;
    model_run(s, exp_count, exp_addr);
    clear_monitor();
    pattern = s;
    start   = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
    pattern = $urandom;
    check({tag, " busy_after_start"}, {busy, done}, 2'b10);
    cyc = 0;
    while (!done && cyc < RUN_LEN + 20) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, " run_length"}, cyc, RUN_LEN);
    check({tag, " pass"}, pass, exp_count == 0);
    check({tag, " fail_count"}, fail_count, exp_count);
    check({tag, " fail_address"}, fail_address, exp_addr);
    check({tag, " busy_at_done"}, busy, 0);
    repeat (3) @(posedge clock);
    #1;
    check({tag, " hold_flags"}, {busy, done, pass}, {1'b0, 1'b1, exp_count == 0});
    werr = 0;
    rerr = 0;
    check({tag, " write_count"}, wr_addr_q.size(), DEPTH * PASSES);
    check({tag, " read_count"}, rd_addr_q.size(), DEPTH * PASSES);
    for (int i = 0; i < wr_addr_q.size() && i < DEPTH * PASSES; i++) begin
      if (wr_addr_q[i] != ADDR_W'(i % DEPTH) || wr_data_q[i] != ref_word(s, i % DEPTH, i / DEPTH)) werr++;
    end
    for (int i = 0; i < rd_addr_q.size() && i < DEPTH * PASSES; i++) begin
      if (rd_addr_q[i] != ADDR_W'(i % DEPTH)) rerr++;
    end
    check({tag, " write_sequence_errors"}, werr, 0);
    check({tag, " read_sequence_errors"}, rerr, 0);
    check({tag, " strobe_overlap"}, overlap_seen, 0);
    check({tag, " idle_bus_nonzero"}, idle_dirty, 0);
  endtask

  initial begin
    int a;
    int b;
    reset   = 1'b1;
    start   = 1'b0;
    pattern = '0;
    clear_faults();
    repeat (3) @(posedge clock);
    #1;
    check("reset_status", {busy, done, pass, mem_rE, mem_wE}, 5'b0);
    check("reset_address", mem_address, 0);
    check("reset_data", mem_data, 0);
    check("reset_fail_address", fail_address, 0);
    check("reset_fail_count", fail_count, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Fault-free memory with a fixed seed.
    run_test("clean_a5a5", 32'hA5A5_0000, 1'b0);

    // Address 7 bit 0 stuck at 1.
    clear_faults();
    force1[7] = 32'h0000_0001;
    run_test("stuck_addr7", 32'h0000_0000, 1'b0);

    // Every read returns zero.
    for (int i = 0; i < DEPTH; i++) force0[i] = '1;
    run_test("read_zero", 32'hFFFF_FFFF, 1'b0);
    clear_faults();

    // Reset in the middle of a run aborts it.
    clear_monitor();
    pattern = $urandom;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (39) @(posedge clock);
    #1;
    check("abort_busy_before_reset", busy, 1);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1;
    check("abort_status", {busy, done, pass, mem_rE, mem_wE}, 5'b0);
    check("abort_bus", {mem_address, mem_data}, 0);
    check("abort_fail", {fail_address, fail_count}, 0);
    reset = 1'b0;
    start = 1'b0;
    clear_monitor();
    repeat (5) @(posedge clock);
    #1;
    check("abort_no_strobes", wr_addr_q.size() + rd_addr_q.size(), 0);
    check("abort_idle", {busy, done}, 2'b00);
    run_test("after_abort", 32'h1234_5678, 1'b0);

    // Start held high across the whole run.
    clear_monitor();
    run_test("start_held", 32'h0F0F_F0F0, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    check("start_held_no_restart", {busy, done, 6'(wr_addr_q.size())}, {2'b01, 6'(DEPTH * PASSES)});

    // Randomized seeds and stuck-at faults.
    for (int t = 0; t < 8; t++) begin
      clear_faults();
      for (int f = $urandom_range(0, 5); f > 0; f--) begin
        a = $urandom_range(0, DEPTH - 1);
        b = $urandom_range(0, DATA_W - 1);
        if ($urandom_range(0, 1) == 1) force1[a][b] = 1'b1;
        else force0[a][b] = 1'b1;
      end
      run_test($sformatf("random_%0d", t), $urandom, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
